// File: rtl/iddr_align_ctrl.sv
// Input-delay tap calibration: sweeps a shared tap over all lanes, finds the longest
// contiguous window where q1/q2 match the training pattern, then loads its centre.
module iddr_align_ctrl #(
    parameter int unsigned           WIDTH         = 1,
    parameter int unsigned           TAP_W         = 5,
    parameter int unsigned           SETTLE_CYCLES = 16,
    parameter int unsigned           CHECK_CYCLES  = 64,
    parameter logic [WIDTH-1:0]      PATTERN_Q1    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]      PATTERN_Q2    = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    output logic [TAP_W-1:0] tap,
    output logic             tap_load,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W:0]   win_len
);

    localparam int unsigned MAX_CNT = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES
                                                                     : CHECK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TAP_W-1:0] TAP_MAX     = '1;
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W:0]   LEN_ONE     = (TAP_W+1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StCheck,
        StEval,
        StFinal,
        StDone,
        StFail
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tap_fail_q;
    logic [TAP_W-1:0] cur_start_q;
    logic [TAP_W:0]   cur_len_q;
    logic [TAP_W-1:0] best_start_q;
    logic [TAP_W:0]   best_len_q;

    logic             mismatch;
    logic [TAP_W-1:0] ev_cur_start;
    logic [TAP_W:0]   ev_cur_len;
    logic [TAP_W-1:0] ev_best_start;
    logic [TAP_W:0]   ev_best_len;
    logic [TAP_W:0]   ev_best_half;
    logic [TAP_W-1:0] centre;

    assign mismatch = (q1 != PATTERN_Q1) || (q2 != PATTERN_Q2);

    // Window tracker update for the tap that just finished checking.
    always_comb begin
        ev_cur_start  = cur_start_q;
        ev_cur_len    = cur_len_q;
        ev_best_start = best_start_q;
        ev_best_len   = best_len_q;
        if (!tap_fail_q) begin
            if (cur_len_q == '0) begin
                ev_cur_start = tap;
            end
            ev_cur_len = cur_len_q + LEN_ONE;
            if (ev_cur_len > best_len_q) begin
                ev_best_start = ev_cur_start;
                ev_best_len   = ev_cur_len;
            end
        end else begin
            ev_cur_len = '0;
        end
        ev_best_half = (ev_best_len - LEN_ONE) >> 1;
        centre       = ev_best_start + ev_best_half[TAP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tap_fail_q   <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            tap          <= '0;
            tap_load     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            win_start    <= '0;
            win_len      <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (start) begin
                        state_q      <= StLoad;
                        cur_start_q  <= '0;
                        cur_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                        tap          <= '0;
                        tap_load     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        fail         <= 1'b0;
                        win_start    <= '0;
                        win_len      <= '0;
                    end
                end
                StLoad: begin
                    tap_load <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q      <= '0;
                        tap_fail_q <= 1'b0;
                        state_q    <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        tap_fail_q <= 1'b1;
                    end
                    if (cnt_q == CHECK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StEval: begin
                    cur_start_q  <= ev_cur_start;
                    cur_len_q    <= ev_cur_len;
                    best_start_q <= ev_best_start;
                    best_len_q   <= ev_best_len;
                    tap_load     <= 1'b1;
                    // Final tap is set up here so it is stable during the FINAL strobe.
                    if (tap == TAP_MAX) begin
                        tap     <= (ev_best_len != '0) ? centre : '0;
                        state_q <= StFinal;
                    end else begin
                        tap     <= tap + TAP_ONE;
                        state_q <= StLoad;
                    end
                end
                StFinal: begin
                    tap_load <= 1'b0;
                    busy     <= 1'b0;
                    if (best_len_q != '0) begin
                        done      <= 1'b1;
                        win_start <= best_start_q;
                        win_len   <= best_len_q;
                        state_q   <= StDone;
                    end else begin
                        fail    <= 1'b1;
                        state_q <= StFail;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iddr_align_ctrl.sv
// Directed bench for iddr_align_ctrl: table of pass-masks with expected final results,
// plus hand sequences for reset values and a mid-sweep reset.
module tb_iddr_align_ctrl;

    localparam int WIDTH = 2;
    localparam int TAP_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [TAP_W-1:0] tap;
    logic             tap_load;
    logic             busy;
    logic             done;
    logic             fail;
    logic [TAP_W-1:0] win_start;
    logic [TAP_W:0]   win_len;

    logic [31:0] cur_mask;
    logic        glitch;

    int checks;
    int errors;

    // Lanes see the pattern only at taps whose mask bit is set.
    assign q1 = cur_mask[tap] ? 2'b11 : 2'b00;
    assign q2 = (cur_mask[tap] ? 2'b00 : 2'b11) | {glitch, 1'b0};

    iddr_align_ctrl #(
        .WIDTH        (WIDTH),
        .TAP_W        (TAP_W),
        .SETTLE_CYCLES(16),
        .CHECK_CYCLES (64),
        .PATTERN_Q1   (2'b11),
        .PATTERN_Q2   (2'b00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .q1       (q1),
        .q2       (q2),
        .tap      (tap),
        .tap_load (tap_load),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .win_start(win_start),
        .win_len  (win_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] mask;
        int          glitch_tap;
        bit          mid_start;
        int          exp_done;
        int          exp_fail;
        int          exp_tap;
        int          exp_ws;
        int          exp_wl;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int loads, busy_cnt, last_tap, n, gcnt;
        bit finished;
        loads = 0; busy_cnt = 0; last_tap = -1; gcnt = 0; finished = 0;
        cur_mask = v.mask;
        glitch = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 4000; n++) begin
            if (tap_load) begin
                loads++;
                last_tap = int'(tap);
            end
            if (busy) busy_cnt++;
            if (done && fail) chk({v.name, "_done_and_fail"}, 1, 0);
            if (!busy && (done || fail)) begin
                finished = 1;
                break;
            end
            if (v.glitch_tap >= 0) begin
                if (tap_load && int'(tap) == v.glitch_tap) gcnt = 1;
                else if (gcnt > 0) gcnt++;
            end
            glitch = (gcnt == 30);
            start  = v.mid_start && (n == 500);
            @(negedge clk);
        end
        glitch = 1'b0;
        start  = 1'b0;
        chk({v.name, "_finished"}, int'(finished), 1);
        chk({v.name, "_done"}, int'(done), v.exp_done);
        chk({v.name, "_fail"}, int'(fail), v.exp_fail);
        chk({v.name, "_tap"}, int'(tap), v.exp_tap);
        chk({v.name, "_final_load_tap"}, last_tap, v.exp_tap);
        chk({v.name, "_win_start"}, int'(win_start), v.exp_ws);
        chk({v.name, "_win_len"}, int'(win_len), v.exp_wl);
        chk({v.name, "_loads"}, loads, 33);
        chk({v.name, "_busy_cycles"}, busy_cnt, 32 * 82 + 1);
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        glitch = 1'b0;
        cur_mask = '0;

        vecs[0] = '{"all_pass",  32'hFFFF_FFFF, -1, 0, 1, 0, 15, 0, 32};
        vecs[1] = '{"win10_17",  win(10, 17),   -1, 0, 1, 0, 13, 10, 8};
        vecs[2] = '{"two_win",   win(3, 5) | win(20, 27), -1, 0, 1, 0, 23, 20, 8};
        vecs[3] = '{"tie",       win(2, 5) | win(12, 15), -1, 0, 1, 0, 3, 2, 4};
        vecs[4] = '{"glitch11",  win(10, 17),   11, 0, 1, 0, 14, 12, 6};
        vecs[5] = '{"none_pass", 32'h0,         -1, 1, 0, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tap", int'(tap), 0);
        chk("rst_outputs", int'({tap_load, busy, done, fail}), 0);
        chk("rst_window", int'({win_start, win_len}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Reset during CHECK at tap 7 aborts the sweep with no final strobe.
        cur_mask = win(10, 17);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 2000; n++) begin
            if (tap_load && tap == 5'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_found_tap7", int'(found), 1);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_tap", int'(tap), 0);
        chk("rst_mid_flags", int'({tap_load, busy, done, fail}), 0);
        chk("rst_mid_window", int'({win_start, win_len}), 0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (tap_load || busy) found = 1;
            @(negedge clk);
        end
        chk("rst_mid_stays_idle", int'(found), 0);

        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
